// File: rtl/bitonic_s1_loader.sv
// bitonic_s1_loader: serial-to-parallel loader with stage-1 compare-exchange; optional short-block padding under BITONIC_S1_PAD_EN
module bitonic_s1_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef BITONIC_S1_PAD_EN
  input  logic             in_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] number_out1,
  output logic [WIDTH-1:0] number_out2,
  output logic [WIDTH-1:0] number_out3,
  output logic [WIDTH-1:0] number_out4,
  output logic [WIDTH-1:0] number_out5,
  output logic [WIDTH-1:0] number_out6,
  output logic [WIDTH-1:0] number_out7,
  output logic [WIDTH-1:0] number_out8
);
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0] state;
  logic [2:0] cnt;
  logic [WIDTH-1:0] lane [8];
  logic [WIDTH-1:0] nxt [8];
  logic acc, pad, pair, desc, done;
  logic [WIDTH-1:0] x, y, mn, mx;
  logic [2:0] lo_i, hi_i;
  assign out_valid = state == FULL;
  assign in_ready = !out_valid;
  assign acc = in_valid && in_ready;
`ifdef BITONIC_S1_PAD_EN
  assign pad = in_last;
`else
  assign pad = 1'b0;
`endif
  assign done = cnt == 3'd7 || pad;
  assign lo_i = {cnt[2:1], 1'b0};
  assign hi_i = {cnt[2:1], 1'b1};
  assign desc = cnt[1];
  // an odd-positioned last element is paired against all-ones padding
  assign pair = cnt[0] || pad;
  assign x = cnt[0] ? lane[lo_i] : in_data;
  assign y = cnt[0] ? in_data : '1;
  assign mn = x < y ? x : y;
  assign mx = x < y ? y : x;
  // next lane contents for an accept: pad fill, then store or compare-exchange
  always_comb begin
    for (int i = 0; i < 8; i++) nxt[i] = (pad && i > int'(cnt)) ? '1 : lane[i];
    if (pair) begin
      nxt[lo_i] = desc ? mx : mn;
      nxt[hi_i] = desc ? mn : mx;
    end else nxt[cnt] = in_data;
  end
  // LOAD collects elements; FULL holds lanes until the output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt <= '0;
      for (int i = 0; i < 8; i++) lane[i] <= '0;
    end else if (acc) begin
      for (int i = 0; i < 8; i++) lane[i] <= nxt[i];
      cnt <= done ? 3'd0 : cnt + 3'd1;
      state <= done ? FULL : LOAD;
    end else if (out_valid && out_ready) state <= LOAD;
  end
  assign number_out1 = lane[0];
  assign number_out2 = lane[1];
  assign number_out3 = lane[2];
  assign number_out4 = lane[3];
  assign number_out5 = lane[4];
  assign number_out6 = lane[5];
  assign number_out7 = lane[6];
  assign number_out8 = lane[7];
endmodule
